// File: rtl/dqm_deframer_pkg.sv
// -----------------------------------------------------------------------------
// dqm_deframer_pkg
// Shared field widths, lock-state and field-phase encodings, and the sync
// distance helper used by the DQM deframer and its sync correlator.
// Frame layout on the wire, MSB first:
//   [SYNC_W sync pattern | DQM_W DQM word | block_size payload bits]
// -----------------------------------------------------------------------------
package dqm_deframer_pkg;

    localparam int SYNC_W = 32;
    localparam int DQM_W  = 16;
    localparam int LEN_W  = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    typedef enum logic [1:0] {
        PH_SYNC    = 2'd0,
        PH_DQM     = 2'd1,
        PH_PAYLOAD = 2'd2
    } phase_e;

    // Hamming distance building block: number of set bits in a sync-wide word.
    function automatic logic [5:0] popcount_sync(input logic [SYNC_W-1:0] v);
        logic [5:0] acc;
        acc = '0;
        for (int i = 0; i < SYNC_W; i++) begin
            acc = acc + {5'd0, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/dqm_deframer_if.sv
// -----------------------------------------------------------------------------
// dqm_deframer_if
// Serial-in / frame-out bundle of the DQM deframer.
//   bit_en, serial_in      : qualified serial bit stream, MSB first
//   sync_word, block_size  : live framing configuration
//   dqm_word, dqm_valid    : recovered DQM word and its one-clk update strobe
//   payload_bit/_valid     : recovered payload stream
//   frame_start            : marks the first payload bit of a frame
//   locked, sync_miss      : lock status and missed-sync pulse
// master = upstream / stimulus side, slave = deframer side.
// -----------------------------------------------------------------------------
interface dqm_deframer_if;
    import dqm_deframer_pkg::*;

    logic              bit_en;
    logic              serial_in;
    logic [SYNC_W-1:0] sync_word;
    logic [LEN_W-1:0]  block_size;
    logic [DQM_W-1:0]  dqm_word;
    logic              dqm_valid;
    logic              payload_bit;
    logic              payload_valid;
    logic              frame_start;
    logic              locked;
    logic              sync_miss;

    modport master (
        output bit_en, serial_in, sync_word, block_size,
        input  dqm_word, dqm_valid, payload_bit, payload_valid,
               frame_start, locked, sync_miss
    );

    modport slave (
        input  bit_en, serial_in, sync_word, block_size,
        output dqm_word, dqm_valid, payload_bit, payload_valid,
               frame_start, locked, sync_miss
    );

endinterface

// File: rtl/dqm_deframer_sync_correlator.sv
// -----------------------------------------------------------------------------
// dqm_sync_correlator
// Keeps the last SYNC_W received bits in a registered shift window and flags
// when the window, including the bit currently presented, is within
// SYNC_ERR_TOL bit errors of sync_word.
//   clk, rst_n  : clock, asynchronous active-low reset (clears the window)
//   bit_en      : shift strobe
//   serial_in   : incoming bit
//   sync_word   : live reference pattern
//   match       : combinational; valid whenever bit_en is high
// -----------------------------------------------------------------------------
module dqm_sync_correlator
    import dqm_deframer_pkg::*;
#(
    parameter int SYNC_ERR_TOL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              serial_in,
    input  logic [SYNC_W-1:0] sync_word,
    output logic              match
);

    localparam logic [5:0] TOL_C = 6'(SYNC_ERR_TOL);

    logic [SYNC_W-1:0] window_q;
    logic [SYNC_W-1:0] window_d;
    logic [SYNC_W-1:0] window_shift;

    // The match is judged on the window as it will be after this bit, so the
    // lock FSM can act on the same bit_en that completes the pattern.
    always_comb begin
        window_shift = {window_q[SYNC_W-2:0], serial_in};
        window_d     = window_q;
        if (bit_en) begin
            window_d = window_shift;
        end
        match = (popcount_sync(window_shift ^ sync_word) <= TOL_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

endmodule

// File: rtl/dqm_deframer.sv
// -----------------------------------------------------------------------------
// dqm_deframer
// Recovers [sync | DQM word | payload] frames from a qualified serial stream.
// Lock FSM: SEARCH (slide every bit) -> VERIFY (expected-position syncs)
// -> LOCKED (flywheel through up to MISS_FRAMES-1 missed syncs).
// DQM word and payload are only emitted while LOCKED.
//   clk    : single clock
//   rst_n  : asynchronous active-low reset, clears state and outputs
//   bus    : dqm_deframer_if.slave (serial in, config in, frame outputs)
// -----------------------------------------------------------------------------
module dqm_deframer
    import dqm_deframer_pkg::*;
#(
    parameter int SYNC_ERR_TOL  = 0,
    parameter int VERIFY_FRAMES = 2,
    parameter int MISS_FRAMES   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    dqm_deframer_if.slave  bus
);

    localparam logic [CNT_W-1:0] VERIFY_CNT = CNT_W'(VERIFY_FRAMES);
    localparam logic [CNT_W-1:0] MISS_CNT   = CNT_W'(MISS_FRAMES);
    localparam logic [LEN_W-1:0] SYNC_LAST  = LEN_W'(SYNC_W - 1);
    localparam logic [LEN_W-1:0] DQM_LAST   = LEN_W'(DQM_W - 1);

    logic match;

    lock_state_e      state_q,         state_d;
    phase_e           phase_q,         phase_d;
    logic [LEN_W-1:0] bit_cnt_q,       bit_cnt_d;
    logic [LEN_W-1:0] blk_len_q,       blk_len_d;
    logic [CNT_W-1:0] good_cnt_q,      good_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,      miss_cnt_d;
    logic [DQM_W-1:0] dqm_sr_q,        dqm_sr_d;
    logic [DQM_W-1:0] dqm_word_q,      dqm_word_d;
    logic             dqm_valid_q,     dqm_valid_d;
    logic             payload_bit_q,   payload_bit_d;
    logic             payload_valid_q, payload_valid_d;
    logic             frame_start_q,   frame_start_d;
    logic             locked_q,        locked_d;
    logic             sync_miss_q,     sync_miss_d;

    dqm_sync_correlator #(
        .SYNC_ERR_TOL (SYNC_ERR_TOL)
    ) u_corr (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bus.bit_en),
        .serial_in (bus.serial_in),
        .sync_word (bus.sync_word),
        .match     (match)
    );

    // Next state: lock FSM and field sequencing, advanced once per bit_en.
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        bit_cnt_d       = bit_cnt_q;
        blk_len_d       = blk_len_q;
        good_cnt_d      = good_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        dqm_sr_d        = dqm_sr_q;
        dqm_word_d      = dqm_word_q;
        payload_bit_d   = payload_bit_q;
        dqm_valid_d     = 1'b0;
        payload_valid_d = 1'b0;
        frame_start_d   = 1'b0;
        sync_miss_d     = 1'b0;

        if (bus.bit_en) begin
            if (state_q == ST_SEARCH) begin
                if (match) begin
                    state_d    = (VERIFY_FRAMES <= 1) ? ST_LOCKED : ST_VERIFY;
                    phase_d    = PH_DQM;
                    bit_cnt_d  = '0;
                    blk_len_d  = bus.block_size;
                    good_cnt_d = CNT_W'(1);
                    miss_cnt_d = '0;
                end
            end else begin
                case (phase_q)
                    PH_SYNC: begin
                        if (bit_cnt_q == SYNC_LAST) begin
                            bit_cnt_d = '0;
                            if (match) begin
                                phase_d    = PH_DQM;
                                blk_len_d  = bus.block_size;
                                miss_cnt_d = '0;
                                if (state_q == ST_VERIFY) begin
                                    good_cnt_d = good_cnt_q + CNT_W'(1);
                                    if (good_cnt_q + CNT_W'(1) >= VERIFY_CNT) begin
                                        state_d = ST_LOCKED;
                                    end
                                end
                            end else begin
                                sync_miss_d = 1'b1;
                                if (state_q == ST_VERIFY) begin
                                    state_d    = ST_SEARCH;
                                    phase_d    = PH_SYNC;
                                    good_cnt_d = '0;
                                end else if (miss_cnt_q + CNT_W'(1) == MISS_CNT) begin
                                    state_d    = ST_SEARCH;
                                    phase_d    = PH_SYNC;
                                    good_cnt_d = '0;
                                    miss_cnt_d = '0;
                                end else begin
                                    // Flywheel: keep framing on the expected grid.
                                    miss_cnt_d = miss_cnt_q + CNT_W'(1);
                                    phase_d    = PH_DQM;
                                    blk_len_d  = bus.block_size;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_W'(1);
                        end
                    end

                    PH_DQM: begin
                        dqm_sr_d = {dqm_sr_q[DQM_W-2:0], bus.serial_in};
                        if (bit_cnt_q == DQM_LAST) begin
                            bit_cnt_d = '0;
                            phase_d   = (blk_len_q == '0) ? PH_SYNC : PH_PAYLOAD;
                            if (state_q == ST_LOCKED) begin
                                dqm_word_d  = dqm_sr_d;
                                dqm_valid_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_W'(1);
                        end
                    end

                    PH_PAYLOAD: begin
                        if (state_q == ST_LOCKED) begin
                            payload_bit_d   = bus.serial_in;
                            payload_valid_d = 1'b1;
                            frame_start_d   = (bit_cnt_q == '0);
                        end
                        if (bit_cnt_q == blk_len_q - LEN_W'(1)) begin
                            bit_cnt_d = '0;
                            phase_d   = PH_SYNC;
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_W'(1);
                        end
                    end

                    default: begin
                        phase_d   = PH_SYNC;
                        bit_cnt_d = '0;
                    end
                endcase
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_SEARCH;
            phase_q         <= PH_SYNC;
            bit_cnt_q       <= '0;
            blk_len_q       <= '0;
            good_cnt_q      <= '0;
            miss_cnt_q      <= '0;
            dqm_sr_q        <= '0;
            dqm_word_q      <= '0;
            dqm_valid_q     <= 1'b0;
            payload_bit_q   <= 1'b0;
            payload_valid_q <= 1'b0;
            frame_start_q   <= 1'b0;
            locked_q        <= 1'b0;
            sync_miss_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            bit_cnt_q       <= bit_cnt_d;
            blk_len_q       <= blk_len_d;
            good_cnt_q      <= good_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            dqm_sr_q        <= dqm_sr_d;
            dqm_word_q      <= dqm_word_d;
            dqm_valid_q     <= dqm_valid_d;
            payload_bit_q   <= payload_bit_d;
            payload_valid_q <= payload_valid_d;
            frame_start_q   <= frame_start_d;
            locked_q        <= locked_d;
            sync_miss_q     <= sync_miss_d;
        end
    end

    assign bus.dqm_word      = dqm_word_q;
    assign bus.dqm_valid     = dqm_valid_q;
    assign bus.payload_bit   = payload_bit_q;
    assign bus.payload_valid = payload_valid_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.locked        = locked_q;
    assign bus.sync_miss     = sync_miss_q;

endmodule

// File: tb/tb_dqm_deframer.sv
// -----------------------------------------------------------------------------
// tb_dqm_deframer
// Directed bench for dqm_deframer. Two instances see the same serial stream:
// u_dut with SYNC_ERR_TOL=0 and u_dut_tol1 with SYNC_ERR_TOL=1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dqm_deframer;
    import dqm_deframer_pkg::*;

    localparam logic [31:0] SW = 32'h1ACFFC1D;

    logic clk;
    logic rst_n;

    dqm_deframer_if bus0();
    dqm_deframer_if bus1();

    assign bus1.bit_en     = bus0.bit_en;
    assign bus1.serial_in  = bus0.serial_in;
    assign bus1.sync_word  = bus0.sync_word;
    assign bus1.block_size = bus0.block_size;

    dqm_deframer #(.SYNC_ERR_TOL(0), .VERIFY_FRAMES(2), .MISS_FRAMES(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    dqm_deframer #(.SYNC_ERR_TOL(1), .VERIFY_FRAMES(2), .MISS_FRAMES(3)) u_dut_tol1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: running event counts, sampled 1 ns after each edge.
    int          n_dqm, n_pay, n_fs, n_fs_bad, n_miss0, n_miss1;
    logic [15:0] last_dqm;
    logic [63:0] pay_hist;

    initial begin
        n_dqm = 0; n_pay = 0; n_fs = 0; n_fs_bad = 0; n_miss0 = 0; n_miss1 = 0;
        last_dqm = '0; pay_hist = '0;
    end

    always @(posedge clk) begin
        #1;
        if (bus0.dqm_valid) begin
            n_dqm    = n_dqm + 1;
            last_dqm = bus0.dqm_word;
        end
        if (bus0.payload_valid) begin
            n_pay    = n_pay + 1;
            pay_hist = {pay_hist[62:0], bus0.payload_bit};
        end
        if (bus0.frame_start) n_fs = n_fs + 1;
        if (bus0.frame_start && !bus0.payload_valid) n_fs_bad = n_fs_bad + 1;
        if (bus0.sync_miss) n_miss0 = n_miss0 + 1;
        if (bus1.sync_miss) n_miss1 = n_miss1 + 1;
    end

    int n_checks, n_errors;
    int b_dqm, b_pay, b_fs, b_miss0, b_miss1;
    int gap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_dqm   = n_dqm;
        b_pay   = n_pay;
        b_fs    = n_fs;
        b_miss0 = n_miss0;
        b_miss1 = n_miss1;
    endtask

    // Called at a negedge; presents one bit for exactly one rising edge.
    task automatic send_bit(input logic b);
        bus0.bit_en    = 1'b1;
        bus0.serial_in = b;
        @(negedge clk);
        bus0.bit_en    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [31:0] s, input logic [15:0] d,
                              input int n, input logic [31:0] p);
        send_bits({32'd0, s}, 32);
        send_bits({48'd0, d}, 16);
        send_bits({32'd0, p}, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0; gap = 0;
        rst_n           = 1'b0;
        bus0.bit_en     = 1'b0;
        bus0.serial_in  = 1'b0;
        bus0.sync_word  = SW;
        bus0.block_size = 16'd8;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_locked",    {63'd0, bus0.locked},        64'd0);
        check("rst_dqm_valid", {63'd0, bus0.dqm_valid},     64'd0);
        check("rst_pay_valid", {63'd0, bus0.payload_valid}, 64'd0);
        check("rst_fs",        {63'd0, bus0.frame_start},   64'd0);
        check("rst_miss",      {63'd0, bus0.sync_miss},     64'd0);
        check("rst_dqm_word",  {48'd0, bus0.dqm_word},      64'd0);
        check("rst_locked1",   {63'd0, bus1.locked},        64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean acquisition, block_size 8
        snap();
        send_frame(SW, 16'h00A5, 8, 32'h11);
        check("acq_f1_locked", {63'd0, bus0.locked}, 64'd0);
        check("acq_f1_dqm", n_dqm - b_dqm, 0);
        send_frame(SW, 16'h00A6, 8, 32'h5A);
        check("acq_f2_locked", {63'd0, bus0.locked}, 64'd1);
        check("acq_f2_dqm_word", {48'd0, last_dqm}, 64'h00A6);
        check("acq_f2_pay_cnt", n_pay - b_pay, 8);
        check("acq_f2_fs", n_fs - b_fs, 1);
        send_frame(SW, 16'h00A7, 8, 32'hC3);
        check("acq_dqm_cnt", n_dqm - b_dqm, 2);
        check("acq_dqm_word", {48'd0, last_dqm}, 64'h00A7);
        check("acq_pay_bits", {48'd0, pay_hist[15:0]}, 64'h5AC3);
        check("acq_miss", n_miss0 - b_miss0, 0);

        // Single corrupted sync bit while locked
        snap();
        send_frame(SW ^ 32'h0000_0001, 16'h00A8, 8, 32'h0F);
        check("err1_miss_tol0", n_miss0 - b_miss0, 1);
        check("err1_miss_tol1", n_miss1 - b_miss1, 0);
        check("err1_locked0", {63'd0, bus0.locked}, 64'd1);
        check("err1_locked1", {63'd0, bus1.locked}, 64'd1);
        check("err1_dqm_word", {48'd0, last_dqm}, 64'h00A8);
        check("err1_pay_bits", {56'd0, pay_hist[7:0]}, 64'h0F);

        // Three consecutive corrupted syncs drop lock, then reacquire
        send_frame(SW, 16'h00A9, 8, 32'h33);
        snap();
        send_frame(SW ^ 32'h0001_0001, 16'h00B0, 8, 32'h01);
        send_frame(SW ^ 32'h0001_0001, 16'h00B1, 8, 32'h02);
        check("loss_after2_locked", {63'd0, bus0.locked}, 64'd1);
        send_frame(SW ^ 32'h0001_0001, 16'h00B2, 8, 32'h03);
        check("loss_locked0", {63'd0, bus0.locked}, 64'd0);
        check("loss_locked1", {63'd0, bus1.locked}, 64'd0);
        check("loss_miss0", n_miss0 - b_miss0, 3);
        check("loss_miss1", n_miss1 - b_miss1, 3);
        check("loss_dqm_cnt", n_dqm - b_dqm, 2);
        check("loss_dqm_word", {48'd0, last_dqm}, 64'h00B1);
        snap();
        send_frame(SW, 16'h00C0, 8, 32'hAA);
        check("reacq_f1_locked", {63'd0, bus0.locked}, 64'd0);
        send_frame(SW, 16'h00C1, 8, 32'h96);
        check("reacq_locked0", {63'd0, bus0.locked}, 64'd1);
        check("reacq_locked1", {63'd0, bus1.locked}, 64'd1);
        check("reacq_dqm_cnt", n_dqm - b_dqm, 1);
        check("reacq_dqm_word", {48'd0, last_dqm}, 64'h00C1);
        check("reacq_pay_bits", {56'd0, pay_hist[7:0]}, 64'h96);

        // Sync at the wrong offset while verifying
        do_reset();
        send_frame(SW, 16'h0011, 8, 32'h55);
        snap();
        send_bits(64'h16, 5);
        send_frame(SW, 16'h0012, 8, 32'h66);
        check("offs_miss", n_miss0 - b_miss0, 1);
        check("offs_dqm_cnt", n_dqm - b_dqm, 0);
        check("offs_pay_cnt", n_pay - b_pay, 0);
        check("offs_locked", {63'd0, bus0.locked}, 64'd0);
        send_frame(SW, 16'h0013, 8, 32'h77);
        check("offs_relock", {63'd0, bus0.locked}, 64'd1);
        check("offs_dqm_word", {48'd0, last_dqm}, 64'h0013);

        // block_size change mid-frame, then header-only frames
        snap();
        send_bits({32'd0, SW}, 32);
        send_bits(64'h00, 8);
        bus0.block_size = 16'd12;
        send_bits(64'hD0, 8);
        send_bits(64'hE1, 8);
        send_frame(SW, 16'h00D1, 12, 32'hABC);
        bus0.block_size = 16'd0;
        send_frame(SW, 16'h00D2, 0, 32'h0);
        send_frame(SW, 16'h00D3, 0, 32'h0);
        check("blk_pay_cnt", n_pay - b_pay, 20);
        check("blk_pay_bits", {44'd0, pay_hist[19:0]}, 64'hE1ABC);
        check("blk_fs", n_fs - b_fs, 2);
        check("blk_dqm_cnt", n_dqm - b_dqm, 4);
        check("blk_dqm_word", {48'd0, last_dqm}, 64'h00D3);
        check("blk_miss", n_miss0 - b_miss0, 0);
        check("blk_locked", {63'd0, bus0.locked}, 64'd1);
        bus0.block_size = 16'd8;

        // bit_en gaps, then asynchronous reset mid-payload
        do_reset();
        gap = 2;
        snap();
        send_frame(SW, 16'h00E0, 8, 32'h81);
        send_frame(SW, 16'h00E1, 8, 32'h42);
        send_frame(SW, 16'h00E2, 8, 32'h24);
        check("gap_locked", {63'd0, bus0.locked}, 64'd1);
        check("gap_dqm_cnt", n_dqm - b_dqm, 2);
        check("gap_dqm_word", {48'd0, last_dqm}, 64'h00E2);
        check("gap_pay_cnt", n_pay - b_pay, 16);
        check("gap_pay_bits", {48'd0, pay_hist[15:0]}, 64'h4224);
        check("gap_fs", n_fs - b_fs, 2);
        send_bits({32'd0, SW}, 32);
        send_bits(64'h00E3, 16);
        send_bits(64'hF, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked0", {63'd0, bus0.locked}, 64'd0);
        check("arst_locked1", {63'd0, bus1.locked}, 64'd0);
        check("arst_dqm_word", {48'd0, bus0.dqm_word}, 64'd0);
        check("arst_pay_bit", {63'd0, bus0.payload_bit}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        @(negedge clk);
        snap();
        send_frame(SW, 16'h00F0, 8, 32'h18);
        send_frame(SW, 16'h00F1, 8, 32'hE7);
        check("post_rst_locked", {63'd0, bus0.locked}, 64'd1);
        check("post_rst_dqm_cnt", n_dqm - b_dqm, 1);
        check("post_rst_dqm_word", {48'd0, last_dqm}, 64'h00F1);
        check("post_rst_pay_bits", {56'd0, pay_hist[7:0]}, 64'hE7);
        check("fs_with_payload", n_fs_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
